// File: rtl/cve2_pkg.sv
// cve2_pkg: shared types and constants for the CVE2 cluster blocks.
// Holds the sleep controller state encoding and wake vector layout.
package cve2_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    SLEEP = 2'd3
  } sleep_state_e;

  localparam int unsigned NumWakeSrc = 4;

  localparam int unsigned WAKE_DEBUG = 0;
  localparam int unsigned WAKE_IRQ   = 1;
  localparam int unsigned WAKE_NMI   = 2;
  localparam int unsigned WAKE_EXT   = 3;

  // True when any wake source is requesting.
  function automatic logic any_wake(
    input logic [NumWakeSrc-1:0] w
  );
    return |w;
  endfunction

endpackage

// File: rtl/cve2_sleep_ctrl_hart.sv
// cve2_sleep_ctrl_hart: one hart's fetch latch, idle hysteresis FSM,
// wake cause register and optional sleep counter (CVE2_SLEEP_STATS_EN).
module cve2_sleep_ctrl_hart
  import cve2_pkg::*;
#(
  parameter int unsigned IdleHoldCycles = 2,
  parameter int unsigned SleepCntWidth  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     fetch_enable_i,
  input  logic                     core_busy_i,
  input  logic [NumWakeSrc-1:0]    wake_i,
  input  logic                     sleep_cnt_clr_i,
  output logic                     fetch_enable_o,
  output logic                     clock_en_o,
  output logic                     core_sleep_o,
  output logic [NumWakeSrc-1:0]    wake_cause_o,
  output logic [SleepCntWidth-1:0] sleep_cnt_o
);

  localparam int unsigned HoldW =
    (IdleHoldCycles > 1) ? $clog2(IdleHoldCycles) : 1;

  localparam logic [HoldW-1:0] HoldInit =
    (IdleHoldCycles > 0) ? HoldW'(IdleHoldCycles - 1) : '0;

  sleep_state_e          state;
  sleep_state_e          state_nxt;
  logic [HoldW-1:0]      hold;
  logic [HoldW-1:0]      hold_nxt;
  logic [NumWakeSrc-1:0] cause;
  logic [NumWakeSrc-1:0] cause_nxt;
  logic                  woke;

  assign woke = any_wake(wake_i);

  // State, hold counter and wake cause registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= OFF;
      hold  <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      cause <= cause_nxt;
    end
  end

  // Next-state: sticky enable, idle hysteresis, wake capture.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    cause_nxt = cause;
    unique case (state)
      OFF: begin
        if (fetch_enable_i) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!core_busy_i && !woke) begin
          if (IdleHoldCycles == 0) begin
            state_nxt = SLEEP;
          end else begin
            state_nxt = HOLD;
            hold_nxt  = HoldInit;
          end
        end
      end
      HOLD: begin
        if (core_busy_i || woke) begin
          state_nxt = RUN;
        end else if (hold == '0) begin
          state_nxt = SLEEP;
        end else begin
          hold_nxt = hold - HoldW'(1);
        end
      end
      SLEEP: begin
        // Busy is frozen while gated, so only wake matters here.
        if (woke) begin
          state_nxt = RUN;
          cause_nxt = wake_i;
        end
      end
      default: begin
        state_nxt = OFF;
      end
    endcase
  end

  // Gate enable and sleep flag; wake ungates in the same cycle.
  always_comb begin
    clock_en_o   = 1'b0;
    core_sleep_o = 1'b0;
    unique case (state)
      RUN, HOLD: begin
        clock_en_o = 1'b1;
      end
      SLEEP: begin
        clock_en_o   = woke;
        core_sleep_o = !woke;
      end
      default: begin
        clock_en_o = 1'b0;
      end
    endcase
  end

  assign fetch_enable_o = (state != OFF);
  assign wake_cause_o   = cause;

`ifdef CVE2_SLEEP_STATS_EN
  logic [SleepCntWidth-1:0] cnt;

  // Saturating count of fully gated cycles; clear wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
    end else if (sleep_cnt_clr_i) begin
      cnt <= '0;
    end else if (state == SLEEP && !woke && cnt != '1) begin
      cnt <= cnt + SleepCntWidth'(1);
    end
  end

  assign sleep_cnt_o = cnt;
`else
  logic unused_clr;

  assign unused_clr  = sleep_cnt_clr_i;
  assign sleep_cnt_o = '0;
`endif

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// cve2_sleep_ctrl: multi-hart clock-gate and sleep controller top.
// Sleep counters exist only when CVE2_SLEEP_STATS_EN is defined.
module cve2_sleep_ctrl
  import cve2_pkg::*;
#(
  parameter int unsigned NumHarts       = 2,
  parameter int unsigned IdleHoldCycles = 2,
  parameter int unsigned SleepCntWidth  = 32
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumHarts-1:0]               fetch_enable_i,
  input  logic [NumHarts-1:0]               core_busy_i,
  input  logic [NumHarts*NumWakeSrc-1:0]    wake_i,
  input  logic [NumHarts-1:0]               sleep_cnt_clr_i,
  output logic [NumHarts-1:0]               fetch_enable_o,
  output logic [NumHarts-1:0]               clock_en_o,
  output logic [NumHarts-1:0]               core_sleep_o,
  output logic [NumHarts*NumWakeSrc-1:0]    wake_cause_o,
  output logic [NumHarts*SleepCntWidth-1:0] sleep_cnt_o
);

  for (genvar h = 0; h < NumHarts; h++) begin : g_hart
    cve2_sleep_ctrl_hart #(
      .IdleHoldCycles (IdleHoldCycles),
      .SleepCntWidth  (SleepCntWidth)
    ) u_hart (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .fetch_enable_i  (fetch_enable_i[h]),
      .core_busy_i     (core_busy_i[h]),
      .wake_i          (wake_i[h*NumWakeSrc +: NumWakeSrc]),
      .sleep_cnt_clr_i (sleep_cnt_clr_i[h]),
      .fetch_enable_o  (fetch_enable_o[h]),
      .clock_en_o      (clock_en_o[h]),
      .core_sleep_o    (core_sleep_o[h]),
      .wake_cause_o    (wake_cause_o[h*NumWakeSrc +: NumWakeSrc]),
      .sleep_cnt_o     (sleep_cnt_o[h*SleepCntWidth +: SleepCntWidth])
    );
  end

endmodule
